// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   - FSM state encoding (2 bits)
//   - BCD digit geometry constants
//   - clog2 constant function for elaboration-time sizing
package bcd_conv_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One fold step of the BCD-to-binary conversion: next = acc*10 + digit.
// Ports:
//   acc       in  BIN_W  running binary value
//   digit     in  4      BCD nibble to append
//   next_acc  out BIN_W  low BIN_W bits of acc*10 + digit
//   digit_bad out 1      nibble was > 9 (it then contributes 0)
//   ovf       out 1      the BIN_W+4-bit intermediate spilled above BIN_W
module bcd_digit_mac
  import bcd_conv_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       next_acc,
  output logic                   digit_bad,
  output logic                   ovf
);

  logic [BIN_W+3:0]       acc_wide;
  logic [BIN_W+3:0]       sum_wide;
  logic [BCD_DIGIT_W-1:0] digit_eff;

  always_comb begin
    acc_wide  = {4'b0000, acc};
    digit_bad = (digit > BCD_DIGIT_W'(BCD_MAX_DIGIT));
    digit_eff = digit_bad ? '0 : digit;
    // acc*10 as a shift-add; acc < 2^BIN_W so acc*10+9 always fits in BIN_W+4 bits
    sum_wide  = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digit_eff};
    next_acc  = sum_wide[BIN_W-1:0];
    ovf       = |sum_wide[BIN_W+3:BIN_W];
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Multi-cycle BCD-to-binary converter, most significant digit first,
// one digit per clock, with valid/ready handshakes on both sides.
// Ports:
//   clk        in  1             rising-edge clock
//   reset      in  1             asynchronous active-high reset
//   in_valid   in  1             bcd_in holds a word to convert
//   in_ready   out 1             high only while idle
//   bcd_in     in  4*NUM_DIGITS  packed BCD, top nibble most significant
//   out_valid  out 1             result and flags valid
//   out_ready  in  1             consumer accepts the result
//   bin_out    out BIN_W         binary value mod 2^BIN_W
//   bad_digit  out 1             some nibble was > 9
//   overflow   out 1             true value >= 2^BIN_W
module bcd_to_bin_seq
  import bcd_conv_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            bad_digit,
  output logic                            overflow
);

  localparam int IN_W  = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1) begin : g_bad_param
    $error("bcd_to_bin_seq: NUM_DIGITS must be >= 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  shreg;
  logic [BIN_W-1:0] acc;
  logic             bad_r;
  logic             ovf_r;

  logic [BIN_W-1:0] mac_acc;
  logic             mac_bad;
  logic             mac_ovf;

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc       (acc),
    .digit     (shreg[IN_W-1 -: BCD_DIGIT_W]),
    .next_acc  (mac_acc),
    .digit_bad (mac_bad),
    .ovf       (mac_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)           state_nxt = ST_CONV;
      ST_CONV: if (cnt == LAST_CNT)    state_nxt = ST_DONE;
      ST_DONE: if (out_ready)          state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch on accept, fold one digit per edge while converting,
  // hold everything in DONE so the result is stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      shreg <= '0;
      acc   <= '0;
      bad_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      cnt   <= '0;
      shreg <= bcd_in;
      acc   <= '0;
      bad_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == ST_CONV) begin
      cnt   <= cnt + 1'b1;
      shreg <= shreg << BCD_DIGIT_W;
      acc   <= mac_acc;
      bad_r <= bad_r | mac_bad;
      // sticky: once wrapped, later steps on the truncated value cannot clear it
      ovf_r <= ovf_r | mac_ovf;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign bin_out   = acc;
  assign bad_digit = bad_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq. Two instances share all inputs:
// one with default parameters (BIN_W=14) and one with BIN_W=10, so every
// word also exercises the wrap/overflow behaviour of the narrow instance.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] bcd_in;

  logic        a_in_ready, a_out_valid, a_bad, a_ovf;
  logic [13:0] a_bin;
  logic        b_in_ready, b_out_valid, b_bad, b_ovf;
  logic [9:0]  b_bin;

  int n_total;
  int n_bad;
  int cyc;
  int t_acc;
  int t_first;

  bcd_to_bin_seq #(.NUM_DIGITS(4), .BIN_W(14)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .bcd_in    (bcd_in),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .bin_out   (a_bin),
    .bad_digit (a_bad),
    .overflow  (a_ovf)
  );

  bcd_to_bin_seq #(.NUM_DIGITS(4), .BIN_W(10)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .bcd_in    (bcd_in),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .bin_out   (b_bin),
    .bad_digit (b_bad),
    .overflow  (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one word with out_ready high, starting from IDLE at a negedge.
  // v is the decimal value of the word with bad nibbles counted as 0.
  task automatic run_word(input logic [15:0] w, input int v, input int bd, input string tag);
    int lat;
    bcd_in    = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t_acc    = cyc;
    check({tag, "_rdy_conv"}, a_in_ready, 0);
    check({tag, "_b_rdy_conv"}, b_in_ready, 0);
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_a_bin"}, a_bin, v);
    check({tag, "_a_bad"}, a_bad, bd);
    check({tag, "_a_ovf"}, a_ovf, 0);
    check({tag, "_rdy_done"}, a_in_ready, 0);
    check({tag, "_b_vld"}, b_out_valid, 1);
    check({tag, "_b_bin"}, b_bin, v % 1024);
    check({tag, "_b_bad"}, b_bad, bd);
    check({tag, "_b_ovf"}, b_ovf, (v >= 1024) ? 1 : 0);
    @(negedge clk);
    check({tag, "_vld_drop"}, a_out_valid, 0);
    check({tag, "_rdy_back"}, a_in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = 16'h0000;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_bin", a_bin, 0);
    check("rst_bad", a_bad, 0);
    check("rst_ovf", a_ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    // full-scale value
    run_word(16'h9999, 9999, 0, "w9999");

    // back-to-back words, throughput of NUM_DIGITS+2 cycles
    run_word(16'h0000, 0, 0, "w0000");
    t_first = t_acc;
    run_word(16'h0001, 1, 0, "w0001");
    check("throughput", t_acc - t_first, 6);

    // invalid nibble contributes 0
    run_word(16'h12A4, 1204, 1, "w12A4");

    // narrow-instance boundary
    run_word(16'h1024, 1024, 0, "w1024");
    run_word(16'h1023, 1023, 0, "w1023");

    // backpressure: result held while out_ready low, new word refused
    bcd_in    = 16'h0042;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    bcd_in = 16'h0099;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hold_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", a_out_valid, 1);
      check("hold_bin", a_bin, 42);
      check("hold_rdy", a_in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_vld", a_out_valid, 0);
    check("hold_release_rdy", a_in_ready, 1);
    run_word(16'h0099, 99, 0, "w0099");

    // asynchronous reset during the second CONV cycle
    bcd_in    = 16'h5678;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_in_ready", a_in_ready, 1);
    check("arst_out_valid", a_out_valid, 0);
    check("arst_bin", a_bin, 0);
    check("arst_b_bin", b_bin, 0);
    check("arst_bad", a_bad, 0);
    check("arst_ovf", a_ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_out_valid) seen = 1;
    end
    check("arst_no_out_valid", seen, 0);
    run_word(16'h0007, 7, 0, "w0007");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
